divider_param: RTL

- Parametrised, iterative, restoring integer divider for the arithmetic processor datapath. It is the next generation of the 8-bit divider.
- Adds the following over the 8-bit divider:
  - generic WIDTH
  - run-time signed/unsigned mode
  - explicit start/busy/done handshake
  - correct remainder sign
  - divide-by-zero and overflow flags
  - asynchronous reset
- Produces one quotient bit per clock. Sits beside the multiplier and is controlled by the multicycle control FSM.

---
 rtl/divider_param.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/divider_param.sv
// divider_param: iterative restoring integer divider, one quotient bit per clock.
// Supports run-time signed (two's-complement) or unsigned operation, with a
// start/busy/done handshake and sticky-until-next-result divide-by-zero and
// signed-overflow flags. The remainder takes the sign of the dividend.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while busy=0
//   signed_mode  1 = signed operands/results, 0 = unsigned (sampled with start)
//   dividend     numerator (sampled with start)
//   divisor      denominator (sampled with start)
//   busy         operation in progress
//   done         one-cycle pulse, results valid
//   quotient     result quotient, held until the next result
//   remainder    result remainder, held until the next result
//   div_by_zero  divisor was zero for the last result
//   overflow     signed most-negative / -1 occurred for the last result
module divider_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // The most-negative value maps onto itself, which is also its correct
  // unsigned magnitude, so no extra bit is needed.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sm);
    return (sm && x[WIDTH-1]) ? neg2c(x) : x;
  endfunction

  // Control and result registers (asynchronously reset).
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_pend_q, dz_pend_d;
  logic             ovf_pend_q, ovf_pend_d;

  // Working datapath registers (no reset; only meaningful while busy).
  // dvd_q shifts the dividend magnitude out of its MSB while quotient bits
  // shift in at its LSB, so it ends up holding the unsigned quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] raw_q, raw_d;

  logic [WIDTH:0]   prem_shift;
  logic [WIDTH:0]   trial;

  assign prem_shift = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign trial      = prem_shift - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    dz_pend_d  = dz_pend_q;
    ovf_pend_d = ovf_pend_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    prem_d     = prem_q;
    raw_d      = raw_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d      = mag(dividend, signed_mode);
          dvs_d      = mag(divisor, signed_mode);
          raw_d      = dividend;
          prem_d     = '0;
          q_neg_d    = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d    = signed_mode & dividend[WIDTH-1];
          dz_pend_d  = (divisor == '0);
          ovf_pend_d = signed_mode && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                       && (divisor == '1);
          cnt_d      = CNT_W'(WIDTH);
          state_d    = (divisor == '0) ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        // Restoring step: keep the trial difference only if it is non-negative.
        if (!trial[WIDTH]) begin
          prem_d = trial;
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d = prem_shift;
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (dz_pend_q) begin
          quo_d = '1;
          rem_d = raw_q;
        end else begin
          quo_d = q_neg_q ? neg2c(dvd_q) : dvd_q;
          rem_d = r_neg_q ? neg2c(prem_q[WIDTH-1:0]) : prem_q[WIDTH-1:0];
        end
        dz_d    = dz_pend_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dz_pend_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      dz_pend_q  <= dz_pend_d;
      ovf_pend_q <= ovf_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    prem_q <= prem_d;
    raw_q  <= raw_d;
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;
  assign overflow    = ovf_q;

endmodule
